// File: rtl/subtractor_pipe.sv
// Segmented, pipelined subtractor: diff = in0 - in1 - bin, one segment and one borrow hop per stage.
// A single advance enable moves or holds every stage together; flags ride with the result.
module subtractor_pipe #(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int NS  = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
  localparam int SEG = WIDTH / NS;

  if (NUM_STAGES < 1 || (WIDTH % NS) != 0) begin : g_param_check
    $fatal(1, "subtractor_pipe: WIDTH must be a multiple of NUM_STAGES, NUM_STAGES >= 1");
  end

  // Stage k register holds segments 0..k of the result plus the operand segments still to go.
  logic [WIDTH-1:0] a_q  [NS];
  logic [WIDTH-1:0] b_q  [NS];
  logic [WIDTH-1:0] df_q [NS];
  logic [WIDTH-1:0] a_d  [NS];
  logic [WIDTH-1:0] b_d  [NS];
  logic [WIDTH-1:0] df_d [NS];
  logic [WIDTH-1:0] a_s  [NS];
  logic [WIDTH-1:0] b_s  [NS];
  logic [WIDTH-1:0] d_s  [NS];
  logic [NS-1:0]    vld_q, vld_d, vld_s;
  logic [NS-1:0]    bor_q, bor_d, bor_s;
  logic [NS-1:0]    zr_q,  zr_d,  zr_s;
  logic [NS-1:0]    am_q,  am_d,  am_s;
  logic [NS-1:0]    bm_q,  bm_d,  bm_s;
  logic             en;

  assign en       = !vld_q[NS-1] || out_ready;
  assign in_ready = en;

  always_comb begin
    logic [WIDTH-1:0] ones;
    logic [SEG:0]     seg;
    ones     = '1;
    seg      = '0;
    a_s[0]   = in0;
    b_s[0]   = in1;
    d_s[0]   = '0;
    vld_s[0] = in_valid;
    bor_s[0] = bin;
    zr_s[0]  = 1'b1;
    am_s[0]  = in0[WIDTH-1];
    bm_s[0]  = in1[WIDTH-1];
    for (int unsigned k = 1; k < NS; k++) begin
      a_s[k]   = a_q[k-1];
      b_s[k]   = b_q[k-1];
      d_s[k]   = df_q[k-1];
      vld_s[k] = vld_q[k-1];
      bor_s[k] = bor_q[k-1];
      zr_s[k]  = zr_q[k-1];
      am_s[k]  = am_q[k-1];
      bm_s[k]  = bm_q[k-1];
    end
    for (int unsigned k = 0; k < NS; k++) begin
      seg = {1'b0, a_s[k][k*SEG +: SEG]} - {1'b0, b_s[k][k*SEG +: SEG]}
          - {{SEG{1'b0}}, bor_s[k]};
      // Consumed operand segments are forced to zero so their flops reduce away.
      a_d[k]  = a_s[k] & (ones << ((k + 1) * SEG));
      b_d[k]  = b_s[k] & (ones << ((k + 1) * SEG));
      df_d[k] = d_s[k];
      df_d[k][k*SEG +: SEG] = seg[SEG-1:0];
      vld_d[k] = vld_s[k];
      bor_d[k] = seg[SEG];
      zr_d[k]  = zr_s[k] && (seg[SEG-1:0] == '0);
      am_d[k]  = am_s[k];
      bm_d[k]  = bm_s[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      bor_q <= '0;
      zr_q  <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      for (int unsigned k = 0; k < NS; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        df_q[k] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      bor_q <= bor_d;
      zr_q  <= zr_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      for (int unsigned k = 0; k < NS; k++) begin
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        df_q[k] <= df_d[k];
      end
    end
  end

  assign out_valid = vld_q[NS-1];
  assign diff      = df_q[NS-1];
  assign bout      = bor_q[NS-1];
  assign zero      = zr_q[NS-1];
  assign ovf       = (am_q[NS-1] != bm_q[NS-1]) && (df_q[NS-1][WIDTH-1] != am_q[NS-1]);

endmodule

// File: tb/tb_subtractor_pipe.sv
// Directed bench for subtractor_pipe at 16/4, 16/1 and 24/3, plus stall-stream and mid-stream reset.
module tb_subtractor_pipe;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        bin;
    logic [23:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, out_ready, bin;
  logic [15:0] in0, in1;
  logic        iv24, bin24;
  logic [23:0] a24, b24;
  logic        or1, or3;

  logic        rdy4, ov4, bo4, of4, z4;
  logic [15:0] d4;
  logic        rdy1, ov1, bo1, of1, z1;
  logic [15:0] d1;
  logic        rdy3, ov3, bo3, of3, z3;
  logic [23:0] d3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  subtractor_pipe #(.WIDTH(16), .NUM_STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy4), .in0(in0), .in1(in1), .bin(bin),
    .out_valid(ov4), .out_ready(out_ready), .diff(d4), .bout(bo4), .ovf(of4), .zero(z4));

  subtractor_pipe #(.WIDTH(16), .NUM_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy1), .in0(in0), .in1(in1), .bin(bin),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1), .ovf(of1), .zero(z1));

  subtractor_pipe #(.WIDTH(24), .NUM_STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(rdy3), .in0(a24), .in1(b24), .bin(bin24),
    .out_valid(ov3), .out_ready(or3), .diff(d3), .bout(bo3), .ovf(of3), .zero(z3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic slot_t ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] r;
    slot_t s;
    r    = {1'b0, a} - {1'b0, b} - {16'b0, bi};
    s.v  = 1'b1;
    s.d  = r[15:0];
    s.bo = r[16];
    s.ov = (a[15] != b[15]) && (r[15] != a[15]);
    s.z  = (r[15:0] == 16'h0);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  v16 [8];
    vec_t  v24 [8];
    slot_t m   [4];
    int    sent, got;
    logic  en;

    v16[0] = '{24'h0005, 24'h0003, 1'b0, 24'h0002, 1'b0, 1'b0, 1'b0};
    v16[1] = '{24'h0000, 24'h0001, 1'b0, 24'hFFFF, 1'b1, 1'b0, 1'b0};
    v16[2] = '{24'h8000, 24'h0001, 1'b0, 24'h7FFF, 1'b0, 1'b1, 1'b0};
    v16[3] = '{24'h7FFF, 24'hFFFF, 1'b0, 24'h8000, 1'b1, 1'b1, 1'b0};
    v16[4] = '{24'h1234, 24'h1233, 1'b1, 24'h0000, 1'b0, 1'b0, 1'b1};
    v16[5] = '{24'h0000, 24'h0000, 1'b1, 24'hFFFF, 1'b1, 1'b0, 1'b0};
    v16[6] = '{24'h8000, 24'h8000, 1'b0, 24'h0000, 1'b0, 1'b0, 1'b1};
    v16[7] = '{24'h0100, 24'h00FF, 1'b0, 24'h0001, 1'b0, 1'b0, 1'b0};

    v24[0] = '{24'h000005, 24'h000003, 1'b0, 24'h000002, 1'b0, 1'b0, 1'b0};
    v24[1] = '{24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    v24[2] = '{24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1'b0, 1'b1, 1'b0};
    v24[3] = '{24'h7FFFFF, 24'hFFFFFF, 1'b0, 24'h800000, 1'b1, 1'b1, 1'b0};
    v24[4] = '{24'h123456, 24'h123455, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1};
    v24[5] = '{24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    v24[6] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
    v24[7] = '{24'h010000, 24'h00FFFF, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; iv = 1'b0; out_ready = 1'b1; bin = 1'b0; in0 = '0; in1 = '0;
    iv24 = 1'b0; bin24 = 1'b0; a24 = '0; b24 = '0; or1 = 1'b1; or3 = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst n4 out_valid", ov4, 0);
    chk("rst n4 diff", d4, 0);
    chk("rst n4 bout", bo4, 0);
    chk("rst n4 ovf", of4, 0);
    chk("rst n4 zero", z4, 0);
    chk("rst n4 in_ready", rdy4, 1);
    chk("rst n1 out_valid", ov1, 0);
    chk("rst n3 out_valid", ov3, 0);
    chk("rst n3 diff", d3, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle n4 in_ready", rdy4, 1);
    chk("idle n4 out_valid", ov4, 0);

    // Directed vectors: 1-edge latency at N=1, 3 edges at 24/3, 4 edges... at N=4 after edge t+3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in0 = v16[i].a[15:0]; in1 = v16[i].b[15:0]; bin = v16[i].bin; iv = 1'b1;
      a24 = v24[i].a; b24 = v24[i].b; bin24 = v24[i].bin; iv24 = 1'b1;
      @(negedge clk);
      iv = 1'b0; iv24 = 1'b0;
      chk($sformatf("v%0d n1 out_valid", i), ov1, 1);
      chk($sformatf("v%0d n1 diff", i), d1, v16[i].d[15:0]);
      chk($sformatf("v%0d n1 bout", i), bo1, v16[i].bo);
      chk($sformatf("v%0d n1 ovf", i), of1, v16[i].ov);
      chk($sformatf("v%0d n1 zero", i), z1, v16[i].z);
      chk($sformatf("v%0d n4 early out_valid", i), ov4, 0);
      chk($sformatf("v%0d n3 early out_valid", i), ov3, 0);
      @(negedge clk);
      chk($sformatf("v%0d n1 drop out_valid", i), ov1, 0);
      @(negedge clk);
      chk($sformatf("v%0d n3 out_valid", i), ov3, 1);
      chk($sformatf("v%0d n3 diff", i), d3, v24[i].d);
      chk($sformatf("v%0d n3 bout", i), bo3, v24[i].bo);
      chk($sformatf("v%0d n3 ovf", i), of3, v24[i].ov);
      chk($sformatf("v%0d n3 zero", i), z3, v24[i].z);
      chk($sformatf("v%0d n4 early2 out_valid", i), ov4, 0);
      @(negedge clk);
      chk($sformatf("v%0d n4 out_valid", i), ov4, 1);
      chk($sformatf("v%0d n4 diff", i), d4, v16[i].d[15:0]);
      chk($sformatf("v%0d n4 bout", i), bo4, v16[i].bo);
      chk($sformatf("v%0d n4 ovf", i), of4, v16[i].ov);
      chk($sformatf("v%0d n4 zero", i), z4, v16[i].z);
    end
    @(negedge clk);
    chk("post-vec n4 out_valid", ov4, 0);

    // Stream of 8 random pairs with out_ready dropped for 3 cycles mid-stream
    for (int s = 0; s < 4; s++) m[s] = '0;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c < 8);
      if (sent < 8) begin
        in0 = 16'($urandom); in1 = 16'($urandom); bin = 1'($urandom_range(0, 1)); iv = 1'b1;
      end else begin
        iv = 1'b0;
      end
      #1;
      chk($sformatf("st c%0d out_valid", c), ov4, m[3].v);
      if (m[3].v) begin
        chk($sformatf("st c%0d diff", c), d4, m[3].d);
        chk($sformatf("st c%0d bout", c), bo4, m[3].bo);
        chk($sformatf("st c%0d ovf", c), of4, m[3].ov);
        chk($sformatf("st c%0d zero", c), z4, m[3].z);
      end
      chk($sformatf("st c%0d in_ready", c), rdy4, !m[3].v || out_ready);
      en = !m[3].v || out_ready;
      if (en) begin
        if (m[3].v) got++;
        m[3] = m[2]; m[2] = m[1]; m[1] = m[0];
        if (iv) begin
          m[0] = ref_sub(in0, in1, bin);
          sent++;
        end else begin
          m[0] = '0;
        end
      end
    end
    iv = 1'b0; out_ready = 1'b1;
    chk("st results delivered", got, 8);
    @(negedge clk);
    chk("st drained out_valid", ov4, 0);

    // Reset pulse with three transactions in flight
    @(negedge clk); in0 = 16'h1111; in1 = 16'h0001; bin = 1'b0; iv = 1'b1;
    @(negedge clk); in0 = 16'h2222; in1 = 16'h0002;
    @(negedge clk); in0 = 16'h3333; in1 = 16'h0003;
    @(negedge clk); iv = 1'b0;
    @(negedge clk);
    chk("pre-rst n4 out_valid", ov4, 1);
    chk("pre-rst n4 diff", d4, 16'h1110);
    #2 rst = 1'b1;
    #1;
    chk("async-rst n4 out_valid", ov4, 0);
    chk("async-rst n4 diff", d4, 0);
    chk("async-rst n4 bout", bo4, 0);
    chk("async-rst n4 zero", z4, 0);
    chk("async-rst n4 in_ready", rdy4, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d n4 out_valid", c), ov4, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
